// File: rtl/bram_stream_reader_skid_fifo2.sv
// skid_fifo2: two-entry registered FIFO used to absorb the one-cycle BRAM
// read latency and provide full backpressure on the output stream.
// The head entry is held in a register so o_data is stable while stalled.
module skid_fifo2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_count;
    logic                  w_do_pop;

    // A pop on an empty FIFO has nothing to remove and is ignored.
    assign w_do_pop = i_pop && (r_count != 2'd0);

    // Storage and occupancy update; push+pop together keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, w_do_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= i_data;
                        r_count <= 2'd1;
                    end else if (r_count == 2'd1) begin
                        r_tail  <= i_data;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

    // The reader's issue throttle guarantees a full FIFO is never pushed
    // without a simultaneous pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !w_do_pop && (r_count == 2'd2)));

endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: scans a contiguous BRAM address range (wrapping at
// DEPTH) and turns the 1-cycle-latency RAM output into a valid/ready stream.
// Handshake: a word transfers on a rising edge where o_valid && o_ready;
// o_valid never drops and o_data never changes until that transfer happens.
// Optional build macro BRAM_STREAM_READER_REPEAT_EN adds num_repeat[7:0]:
// the range is scanned num_repeat+1 times back-to-back with a single done.
module bram_stream_reader #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 2**16,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
`ifdef BRAM_STREAM_READER_REPEAT_EN
    input  logic [7:0]            num_repeat,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  ram_rd_en,
    output logic [ADDR_W-1:0]     ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready
);

    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_length;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_delivered;
    logic [7:0]        r_iss_rep;
    logic [7:0]        r_dlv_rep;
    logic              r_inflight;
    logic              r_busy;
    logic              r_done;

    logic [7:0]        w_num_repeat;
    logic              w_pop;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_valid;
    logic [2:0]        w_occ;
    logic              w_rd_en;
    logic [CNT_W-1:0]  w_addr_sum;
    logic [ADDR_W-1:0] w_addr;
    logic [CNT_W-1:0]  w_issued_nxt;
    logic [CNT_W-1:0]  w_delivered_nxt;

`ifdef BRAM_STREAM_READER_REPEAT_EN
    assign w_num_repeat = num_repeat;
`else
    assign w_num_repeat = 8'd0;
`endif

    assign w_pop = w_fifo_valid && o_ready;

    // Occupancy the FIFO will hold once the in-flight read lands and this
    // cycle's pop leaves; a new read is allowed only if room remains for it.
    assign w_occ = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_rd_en = (r_state == S_RUN) && (r_issued < r_length) && (w_occ < 3'd2);

    // base + issued is below 2*DEPTH, so one conditional subtract wraps it.
    assign w_addr_sum = {1'b0, r_base} + r_issued;
    assign w_addr     = (w_addr_sum >= DEPTH_C) ? ADDR_W'(w_addr_sum - DEPTH_C)
                                                : ADDR_W'(w_addr_sum);

    assign w_issued_nxt    = r_issued + CNT_W'(1);
    assign w_delivered_nxt = r_delivered + CNT_W'(1);

    // Scan sequencer: start acceptance, issue/delivery counting, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_length    <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_iss_rep   <= 8'd0;
            r_dlv_rep   <= 8'd0;
            r_inflight  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base      <= base_addr;
                        r_length    <= length;
                        r_issued    <= '0;
                        r_delivered <= '0;
                        r_iss_rep   <= w_num_repeat;
                        r_dlv_rep   <= w_num_repeat;
                        r_busy      <= 1'b1;
                        if (length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Issue side: restart the address sweep for the next pass.
                    if (w_rd_en) begin
                        if ((w_issued_nxt == r_length) && (r_iss_rep != 8'd0)) begin
                            r_issued  <= '0;
                            r_iss_rep <= r_iss_rep - 8'd1;
                        end else begin
                            r_issued <= w_issued_nxt;
                        end
                    end
                    // Delivery side: the last handshake of the last pass ends the scan.
                    if (w_pop) begin
                        if (w_delivered_nxt == r_length) begin
                            if (r_dlv_rep == 8'd0) begin
                                r_delivered <= w_delivered_nxt;
                                r_state     <= S_DONE;
                                r_done      <= 1'b1;
                            end else begin
                                r_delivered <= '0;
                                r_dlv_rep   <= r_dlv_rep - 8'd1;
                            end
                        end else begin
                            r_delivered <= w_delivered_nxt;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    skid_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (ram_rd_data),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign o_valid     = w_fifo_valid;
    assign ram_rd_en   = w_rd_en;
    assign ram_rd_addr = w_addr;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: pipelined RAM model with ram[i]=i, scoreboard
// queues for expected read addresses and stream words, timing checks when
// o_ready is held high. Define BRAM_STREAM_READER_REPEAT_EN for the repeat case.
module tb_bram_stream_reader;

  localparam int DW     = 32;
  localparam int DEPTH  = 2**16;
  localparam int AW     = 16;
  localparam int BUDGET = 300;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [7:0]    num_repeat;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          o_ready;

  int n_checks;
  int n_errors;
  int cyc;

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  bram_stream_reader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
`ifdef BRAM_STREAM_READER_REPEAT_EN
    .num_repeat  (num_repeat),
`endif
    .busy        (busy),
    .done        (done),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_ready     (o_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // RAM model: registered read, contents equal to address
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= DW'(ram_rd_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Runs one scan. mode 0: o_ready held high; mode 1: ready 1 cycle on, 2 off.
  // abort_at != 0: assert reset when that many words have been handed over.
  task automatic run_scan(input int base, input int len, input int rep,
                          input int mode, input int abort_at);
    int t0, first_rd, first_hs, last_hs, done_cyc, rd_cnt, hs_cnt, total;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_w;
    logic [AW-1:0] exp_a;
    bit seen_done, aborted;
    total = len * (rep + 1);
    for (int p = 0; p <= rep; p++)
      for (int i = 0; i < len; i++) begin
        exp_addr_q.push_back(AW'((base + i) % DEPTH));
        exp_q.push_back(DW'((base + i) % DEPTH));
      end
    first_rd = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
    rd_cnt = 0; hs_cnt = 0; prev_stall = 1'b0; prev_data = '0;
    seen_done = 0; aborted = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); num_repeat = 8'(rep);
    o_ready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (prev_stall) begin
        check_eq("stall_valid", 32'(o_valid), 1);
        check_eq("stall_data", o_data, prev_data);
      end
      if (ram_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr_q.size() == 0) check_eq("extra_read", 1, 0);
        else begin
          exp_a = exp_addr_q.pop_front();
          check_eq("rd_addr", 32'(ram_rd_addr), 32'(exp_a));
        end
      end
      if (o_valid && o_ready) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_q.size() == 0) check_eq("extra_word", 1, 0);
        else begin
          exp_w = exp_q.pop_front();
          check_eq("o_data", o_data, exp_w);
        end
      end
      if (ram_rd_en) check_eq("outstanding_le2", 32'((rd_cnt - hs_cnt) <= 2), 1);
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      if (done) begin
        done_cyc = cyc;
        seen_done = 1;
        check_eq("busy_at_done", 32'(busy), 1);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 1) o_ready = ((cyc - t0) % 3 == 0);
      if (abort_at != 0 && hs_cnt == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(o_valid), 0);
        check_eq("abort_rd_en", 32'(ram_rd_en), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        aborted = 1;
        break;
      end
    end
    if (aborted) return;
    check_eq("done_seen", 32'(seen_done), 1);
    check_eq("addr_q_empty", 32'(exp_addr_q.size()), 0);
    check_eq("data_q_empty", 32'(exp_q.size()), 0);
    check_eq("read_count", 32'(rd_cnt), 32'(total));
    if (mode == 0 && seen_done) begin
      if (total == 0) begin
        check_eq("done_cycle_len0", 32'(done_cyc - t0), 1);
      end else begin
        check_eq("first_rd_cycle", 32'(first_rd - t0), 1);
        check_eq("first_valid_cycle", 32'(first_hs - t0), 3);
        check_eq("last_hs_cycle", 32'(last_hs - t0), 32'(total + 2));
        check_eq("done_cycle", 32'(done_cyc - t0), 32'(total + 3));
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 0);
    check_eq("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; num_repeat = 8'd0;
    o_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_rd_en", 32'(ram_rd_en), 0);
    check_eq("rst_rd_addr", 32'(ram_rd_addr), 0);
    check_eq("rst_valid", 32'(o_valid), 0);
    check_eq("rst_data", o_data, 0);
    rst_n = 1'b1;

    run_scan(16, 8, 0, 0, 0);
    run_scan(16, 8, 0, 1, 0);
    run_scan(DEPTH - 2, 4, 0, 0, 0);
    run_scan(DEPTH - 2, 4, 0, 1, 0);
    run_scan(0, 0, 0, 0, 0);

    // reset mid-scan at the 4th word, then a fresh scan
    run_scan(0, 8, 0, 0, 3);
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rst_hold_done", 32'(done), 0);
      check_eq("rst_hold_valid", 32'(o_valid), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_scan(0, 2, 0, 0, 0);

    // random lengths and bases under random-ish backpressure
    for (int n = 0; n < 3; n++)
      run_scan(int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(6, 1)), 0,
               int'($urandom_range(1, 0)), 0);

`ifdef BRAM_STREAM_READER_REPEAT_EN
    run_scan(0, 3, 2, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side sequencer for a single-read block RAM (1-cycle registered read latency, read enable gates the output register).
- Scans a contiguous address range and issues ram_rd_en/ram_rd_addr.
- Absorbs the read latency and converts RAM output into a valid/ready stream with full backpressure.
- Sits between a weight/feature-map BRAM and the downstream conv datapath; sustains 1 word/cycle when o_ready is held high.

Parameters:
- DATA_WIDTH, 32, word width; must match the RAM.
- DEPTH, 2**16, RAM depth in words; ADDR_W = $clog2(DEPTH) is a derived localparam.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- base_addr  in  ADDR_W  first address; sampled on accepted start.
- length  in  ADDR_W+1  number of words, 0..DEPTH; sampled on accepted start.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan completes.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_WIDTH  RAM read data; valid the cycle after ram_rd_en.
- o_data  out  DATA_WIDTH  stream data.
- o_valid  out  1  stream valid.
- o_ready  in  1  stream ready.

Behaviour:
- Reset values: busy=0, done=0, ram_rd_en=0, ram_rd_addr=0, o_valid=0, o_data=0. All counters cleared, FIFO empty.
- Reset mid-scan aborts immediately. No done pulse. In-flight RAM data is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 and length!=0 -> RUN; latch base_addr and length; clear issued/delivered counters.
  - IDLE: start=1 and length==0 -> DONE; no RAM reads.
  - RUN -> DONE when delivered==length, i.e. the last o_valid&o_ready handshake has occurred.
  - DONE -> IDLE unconditionally after 1 cycle; done=1 only in DONE.
- busy=1 in RUN and DONE. start while busy is ignored.
- Read issue, RUN only:
  - ram_rd_en = (issued < length) && (fifo_count + inflight - pop < 2).
  - pop = o_valid & o_ready; inflight = ram_rd_en of the previous cycle.
  - ram_rd_addr = (base + issued) mod DEPTH, wrapping past DEPTH-1 to 0.
  - ram_rd_en and ram_rd_addr are combinational from registered state.
  - ram_rd_en=0 outside RUN.
- Capture: in the cycle after ram_rd_en, ram_rd_data is written into a 2-entry FIFO. It never overflows; overflow is an assertion failure.
- Output: o_valid = FIFO non-empty; o_data = FIFO head (registered).
  - o_data is stable while o_valid & !o_ready.
  - A simultaneous push and pop keeps the count unchanged.
- Latency:
  - Accepted start at cycle T -> first ram_rd_en at T+1 -> first o_valid at T+3.
  - With o_ready held high, one word per cycle thereafter.
  - done at the cycle after the last handshake.
- Counters are ADDR_W+1 bits wide so length=DEPTH terminates correctly.

Optional Feature:
- Macro: BRAM_STREAM_READER_REPEAT_EN.
- With the macro: extra input num_repeat [7:0], sampled on start.
  - The range is re-scanned num_repeat+1 times back-to-back with no bubble between passes (address returns to base).
  - done pulses once after the final pass.
- Without the macro: no num_repeat port; a single pass.

Decomposition:
- No shared package is needed; ADDR_W and the state encoding are local to the module.
- One sub-module, skid_fifo2: 2-entry registered FIFO with push/pop/count, DATA_WIDTH parameter, clk/rst_n.

Test Plan:
- Pipelined RAM model preloaded ram[i]=i; start base=16, length=8, o_ready=1.
  - Expect ram_rd_en at T+1..T+8 with addrs 16..23.
  - Expect o_data 16..23 on consecutive cycles T+3..T+10, done at T+11.
- Same scan with o_ready toggling (1 cycle on, 2 off).
  - Expect all 8 words delivered in order and never more than 2 reads outstanding+buffered.
  - Expect o_data held stable while stalled.
- base=DEPTH-2, length=4.
  - Expect addrs DEPTH-2, DEPTH-1, 0, 1 and matching data.
- length=0.
  - Expect no ram_rd_en, done pulse 1 cycle after start, busy high for exactly that cycle.
- rst_n low at the 4th word of a length=8 scan.
  - Expect o_valid=0, ram_rd_en=0, busy=0 immediately and no done.
  - A following start base=0, length=2 delivers ram[0], ram[1] correctly.
- REPEAT_EN build, num_repeat=2, base=0, length=3, o_ready=1.
  - Expect data 0,1,2,0,1,2,0,1,2 with no gaps and a single done.
